// File: rtl/jk_bank_driver_pkg.sv
// Shared types for the JK bank driver: FSM states, MODE codes, bank width and the step-target rule.
// Pure declarations; no timing or backpressure of its own.
package jk_bank_driver_pkg;

  localparam int BANK_W = 4;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRIVE  = 2'b01,
    ST_CHECK  = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Counting wraps modulo 2**BANK_W in both directions.
  function automatic logic [BANK_W-1:0] next_target(
    input logic [BANK_W-1:0] cur,
    input mode_t             mode,
    input logic [BANK_W-1:0] load_val
  );
    logic [BANK_W-1:0] tgt;
    case (mode)
      MODE_UP:   tgt = cur + {{(BANK_W-1){1'b0}}, 1'b1};
      MODE_DOWN: tgt = cur - {{(BANK_W-1){1'b0}}, 1'b1};
      MODE_LOAD: tgt = load_val;
      default:   tgt = cur;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Control/feedback bundle between a sequencer and the JK bank driver.
// slave = driver side, master = stimulus/bank side; no flow control, single-cycle START request.
interface jk_bank_driver_if;
  import jk_bank_driver_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic [BANK_W-1:0] d;
  logic [LEN_W-1:0]  len;
  logic [BANK_W-1:0] q_fb;
  logic [BANK_W-1:0] j;
  logic [BANK_W-1:0] k;
  logic [BANK_W-1:0] exp;
  logic              busy;
  logic              done;
  logic              err;

  modport slave  (input  start, mode, d, len, q_fb,
                  output j, k, exp, busy, done, err);
  modport master (output start, mode, d, len, q_fb,
                  input  j, k, exp, busy, done, err);

endinterface

// File: rtl/jk_excitation.sv
// Single-bit JK excitation: chooses J/K so a posedge JK flop moves from cur to nxt.
// Combinational, zero latency; never asserts J and K together.
module jk_excitation (
  input  logic cur,
  input  logic nxt,
  output logic j,
  output logic k
);

  assign j = ~cur &  nxt;
  assign k =  cur & ~nxt;

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a 4-bit external JK flop bank through LEN steps (hold/up/down/load), verifying Q after each step.
// START->DONE takes 2*LEN+1 cycles (1 for LEN=0); START is ignored while busy, nothing is queued.
module jk_bank_driver
  import jk_bank_driver_pkg::*;
(
  input logic             clk,
  input logic             rst,
  jk_bank_driver_if.slave bus
);

  state_t            state, state_nxt;
  mode_t             mode_q;
  logic [BANK_W-1:0] d_q;
  logic [BANK_W-1:0] exp_q;
  logic [BANK_W-1:0] tgt;
  logic [LEN_W-1:0]  cnt_q;
  logic              err_q;
  logic [BANK_W-1:0] j_raw, k_raw;
  logic [BANK_W-1:0] j_o, k_o;
  logic              busy_o, done_o;

  assign tgt = next_target(exp_q, mode_q, d_q);

  for (genvar i = 0; i < BANK_W; i++) begin : g_exc
    jk_excitation u_exc (
      .cur (exp_q[i]),
      .nxt (tgt[i]),
      .j   (j_raw[i]),
      .k   (k_raw[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_HOLD;
      d_q    <= '0;
      exp_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q <= mode_t'(bus.mode);
            d_q    <= bus.d;
            cnt_q  <= bus.len;
            exp_q  <= bus.q_fb;
            err_q  <= 1'b0;
          end
        end
        // The external bank captures J/K on this same edge, so EXP tracks it.
        ST_DRIVE: begin
          exp_q <= tgt;
          cnt_q <= cnt_q - 4'd1;
        end
        ST_CHECK: begin
          if (bus.q_fb != exp_q) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    j_o       = '0;
    k_o       = '0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (bus.start) state_nxt = (bus.len != '0) ? ST_DRIVE : ST_FINISH;
      end
      ST_DRIVE: begin
        j_o       = j_raw;
        k_o       = k_raw;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = (cnt_q == '0) ? ST_FINISH : ST_DRIVE;
      end
      ST_FINISH: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.j    = j_o;
  assign bus.k    = k_o;
  assign bus.exp  = exp_q;
  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: external JK bank model, schedule-based reference model with a
// per-cycle comparator, plus directed scenarios with hand-computed literal expectations.
module tb_jk_bank_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_bank_driver_if bif ();

  jk_bank_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // External bank: four posedge JK flops, with an optional stuck-at-0 fault on the feedback.
  logic [3:0] bank    = 4'd0;
  logic [3:0] stuck   = 4'd0;
  logic       pre_vld = 1'b0;
  logic [3:0] pre_val = 4'd0;
  assign bif.q_fb = bank & ~stuck;

  always @(posedge clk) begin
    if (pre_vld) bank <= pre_val;
    else begin
      for (int b = 0; b < 4; b++) begin
        case ({bif.j[b], bif.k[b]})
          2'b10:   bank[b] <= 1'b1;
          2'b01:   bank[b] <= 1'b0;
          2'b11:   bank[b] <= ~bank[b];
          default: ;
        endcase
      end
    end
  end

  // Reference model: on an accepted START the whole expected EXP trajectory is precomputed.
  logic       chk_en   = 1'b0;
  logic       m_active = 1'b0;
  logic       m_err    = 1'b0;
  int         m_len    = 0;
  int         m_cyc    = 0;
  logic [3:0] m_seq [0:15];

  function automatic logic [3:0] m_next(input logic [3:0] e, input logic [1:0] md, input logic [3:0] dv);
    int v;
    case (md)
      2'd0:    v = int'(e);
      2'd1:    v = (int'(e) + 1) % 16;
      2'd2:    v = (int'(e) + 15) % 16;
      default: v = int'(dv);
    endcase
    return v[3:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      chk_en   = 1'b1;
      m_active = 1'b0;
      m_err    = 1'b0;
      m_len    = 0;
      m_seq[0] = 4'd0;
    end else if (!m_active) begin
      if (bif.start) begin
        m_active = 1'b1;
        m_cyc    = 1;
        m_err    = 1'b0;
        m_len    = int'(bif.len);
        m_seq[0] = bif.q_fb;
        for (int i = 1; i <= m_len; i++) m_seq[i] = m_next(m_seq[i-1], bif.mode, bif.d);
      end
    end else begin
      if (m_cyc % 2 == 0 && bif.q_fb != m_seq[m_cyc/2]) m_err = 1'b1;
      if (m_cyc == 2*m_len + 1) m_active = 1'b0;
      else m_cyc++;
    end
  end

  logic [3:0] e_j, e_k, e_x;
  logic       e_b, e_d;
  int         e_i;
  always @(negedge clk) begin
    if (chk_en) begin
      e_j = 4'd0; e_k = 4'd0; e_b = 1'b1; e_d = 1'b0; e_x = m_seq[m_len];
      if (!m_active) e_b = 1'b0;
      else if (m_cyc == 2*m_len + 1) e_d = 1'b1;
      else if (m_cyc % 2 == 1) begin
        e_i = (m_cyc + 1) / 2;
        e_x = m_seq[e_i-1];
        e_j = ~m_seq[e_i-1] &  m_seq[e_i];
        e_k =  m_seq[e_i-1] & ~m_seq[e_i];
      end else e_x = m_seq[m_cyc/2];
      n_cmp++;
      if ({bif.j, bif.k, bif.exp, bif.busy, bif.done, bif.err} !== {e_j, e_k, e_x, e_b, e_d, m_err}) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t got j=%b k=%b exp=%b busy=%b done=%b err=%b want j=%b k=%b exp=%b busy=%b done=%b err=%b",
                 $time, bif.j, bif.k, bif.exp, bif.busy, bif.done, bif.err, e_j, e_k, e_x, e_b, e_d, m_err);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic preload(input logic [3:0] v);
    pre_val = v; pre_vld = 1'b1;
    @(posedge clk); #1;
    pre_vld = 1'b0;
  endtask

  task automatic go(input logic [1:0] md, input logic [3:0] dv, input logic [3:0] l);
    bif.start = 1'b1; bif.mode = md; bif.d = dv; bif.len = l;
    @(posedge clk); #1;
    bif.start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input string name, input int want);
    while (bif.done !== 1'b1 && cyc < 40) tick();
    check(name, cyc, want);
    tick();
  endtask

  int dcount;

  initial begin
    rst = 1'b1; bif.start = 1'b0; bif.mode = 2'd0; bif.d = 4'd0; bif.len = 4'd0;
    repeat (2) @(posedge clk); #1;
    check("reset_state", int'({bif.j, bif.k, bif.exp, bif.busy, bif.done, bif.err}), 0);
    rst = 1'b0;
    tick();

    // Count up three steps from 0000.
    preload(4'b0000);
    go(2'b01, 4'd0, 4'd3);
    check("up3_first_j", int'(bif.j), int'(4'b0001));
    check("up3_first_k", int'(bif.k), 0);
    tick();
    check("up3_exp_step1", int'(bif.exp), int'(4'b0001));
    wait_done("up3_latency", 7);
    check("up3_exp_final", int'(bif.exp), int'(4'b0011));
    check("up3_err", int'(bif.err), 0);

    // Count down one step wraps 0000 -> 1111.
    preload(4'b0000);
    go(2'b10, 4'd0, 4'd1);
    check("down1_j", int'(bif.j), int'(4'b1111));
    check("down1_k", int'(bif.k), 0);
    wait_done("down1_latency", 3);
    check("down1_bank", int'(bank), int'(4'b1111));
    check("down1_exp", int'(bif.exp), int'(4'b1111));

    // Load 1010 over 0101.
    preload(4'b0101);
    go(2'b11, 4'b1010, 4'd1);
    check("load_j", int'(bif.j), int'(4'b1010));
    check("load_k", int'(bif.k), int'(4'b0101));
    wait_done("load_latency", 3);
    check("load_bank", int'(bank), int'(4'b1010));
    check("load_err", int'(bif.err), 0);

    // Feedback bit0 stuck at 0: sticky error.
    preload(4'b0000);
    stuck = 4'b0001;
    go(2'b01, 4'd0, 4'd2);
    tick(); tick();
    check("stuck_err_after_check", int'(bif.err), 1);
    while (bif.done !== 1'b1 && cyc < 40) tick();
    check("stuck_err_at_done", int'(bif.err), 1);
    tick();
    check("stuck_err_idle", int'(bif.err), 1);
    stuck = 4'b0000;

    // LEN=0, START held into FINISH (ignored); accepted START clears ERR.
    bif.start = 1'b1; bif.mode = 2'b11; bif.d = 4'b1001; bif.len = 4'd0;
    @(posedge clk); #1;
    check("len0_done_cycle1", int'(bif.done), 1);
    check("len0_jk", int'({bif.j, bif.k}), 0);
    check("len0_err_cleared", int'(bif.err), 0);
    @(posedge clk); #1;
    bif.start = 1'b0;
    check("len0_busy_start_ignored", int'({bif.busy, bif.done}), 0);
    tick();
    check("len0_no_second_done", int'(bif.done), 0);
    go(2'b01, 4'd0, 4'd0);
    wait_done("len0_up_latency", 1);

    // START pulsed mid-run is dropped.
    preload(4'b0000);
    go(2'b01, 4'd0, 4'd2);
    tick();
    bif.start = 1'b1; bif.mode = 2'b11; bif.d = 4'b1111; bif.len = 4'd0;
    tick();
    bif.start = 1'b0;
    wait_done("busy_ignore_latency", 5);
    check("busy_ignore_exp", int'(bif.exp), int'(4'b0010));

    // Reset during the second DRIVE of a LEN=5 up run.
    preload(4'b0000);
    go(2'b01, 4'd0, 4'd5);
    tick(); tick();
    check("rst_mid_drive2_j", int'(bif.j), int'(4'b0010));
    rst = 1'b1;
    tick();
    check("rst_mid_state", int'({bif.j, bif.k, bif.exp, bif.busy, bif.done}), 0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dcount += int'(bif.done);
    end
    check("rst_mid_no_done", dcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
